// File: rtl/activation_if.sv
// Row-stream interface between the pooling stage and the activation unit.
// The master side drives rows and control; the slave side returns activated rows and frame status.
interface activation_if #(
    parameter int DWIDTH      = 8,
    parameter int DESIGN_SIZE = 16,
    parameter int MASK_WIDTH  = 16
);
    logic                          enable_activation;
    logic                          activation_type;
    logic                          in_data_available;
    logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]         validity_mask;
    logic [DESIGN_SIZE*DWIDTH-1:0] out_data;
    logic                          out_data_available;
    logic                          done_activation;

    modport master (
        output enable_activation,
        output activation_type,
        output in_data_available,
        output inp_data,
        output validity_mask,
        input  out_data,
        input  out_data_available,
        input  done_activation
    );

    modport slave (
        input  enable_activation,
        input  activation_type,
        input  in_data_available,
        input  inp_data,
        input  validity_mask,
        output out_data,
        output out_data_available,
        output done_activation
    );
endinterface

// File: rtl/activation_unit.sv
// Per-lane activation stage: 2-cycle pipeline, frame row counter and done flag, combinational bypass.
// Define ACTIVATION_TANH_EN to build the piecewise-linear tanh selected by activation_type.
module activation_unit #(
    parameter int DWIDTH      = 8,
    parameter int DESIGN_SIZE = 16,
    parameter int MASK_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    activation_if.slave io_act
);
    localparam int ROW_W = DESIGN_SIZE * DWIDTH;
    localparam int CNT_W = $clog2(DESIGN_SIZE) + 1;
    localparam logic [CNT_W-1:0] FRAME_ROWS = CNT_W'(DESIGN_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_row_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic             r_done;
    logic [ROW_W-1:0] r_s1_data;
    logic [ROW_W-1:0] r_s2_data;
    logic [ROW_W-1:0] w_act_row;
    logic             w_accept;
    logic             w_done_next;

    function automatic logic [DWIDTH-1:0] relu_lane(input logic [DWIDTH-1:0] x);
        logic [DWIDTH-1:0] y;
        if (x[DWIDTH-1]) begin
            y = {DWIDTH{1'b0}};
        end else begin
            y = x;
        end
        return y;
    endfunction

`ifdef ACTIVATION_TANH_EN
    // Magnitude is held in 9 bits so that |-128| = 128 is representable.
    function automatic logic [DWIDTH-1:0] tanh_lane(input logic [DWIDTH-1:0] x);
        logic [8:0] x_ext;
        logic [8:0] mag;
        logic [8:0] m;
        logic [8:0] y;
        x_ext = 9'($signed(x));
        if (x_ext[8]) begin
            mag = 9'd0 - x_ext;
        end else begin
            mag = x_ext;
        end
        if (mag < 9'd32) begin
            m = mag;
        end else if (mag < 9'd96) begin
            m = 9'd32 + ((mag - 9'd32) >> 2'd2);
        end else begin
            m = 9'd48;
        end
        if (x_ext[8]) begin
            y = 9'd0 - m;
        end else begin
            y = m;
        end
        return y[DWIDTH-1:0];
    endfunction
`endif

    assign w_cnt_inc = r_row_cnt + CNT_ONE;

    // Per-lane activation and masking of the incoming row (S1 input).
    always_comb begin
        w_act_row = {ROW_W{1'b0}};
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            if (io_act.validity_mask[i]) begin
`ifdef ACTIVATION_TANH_EN
                if (io_act.activation_type) begin
                    w_act_row[i*DWIDTH +: DWIDTH] = tanh_lane(io_act.inp_data[i*DWIDTH +: DWIDTH]);
                end else begin
                    w_act_row[i*DWIDTH +: DWIDTH] = relu_lane(io_act.inp_data[i*DWIDTH +: DWIDTH]);
                end
`else
                w_act_row[i*DWIDTH +: DWIDTH] = relu_lane(io_act.inp_data[i*DWIDTH +: DWIDTH]);
`endif
            end else begin
                w_act_row[i*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM next-state logic; disabling always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        if (!io_act.enable_activation) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ACTIVE: begin
                    if (io_act.in_data_available) begin
                        if (w_cnt_inc == FRAME_ROWS) begin
                            w_state_next = S_DRAIN;
                        end else begin
                            w_state_next = S_ACTIVE;
                        end
                    end else begin
                        w_state_next = r_state;
                    end
                end
                S_DRAIN: begin
                    if (!r_s1_valid && !r_s2_valid) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Frame FSM output decode: row acceptance and done-flag load value.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_ACTIVE: w_accept = io_act.enable_activation & io_act.in_data_available;
            S_DRAIN, S_DONE:  w_accept = 1'b0;
            default:          w_accept = 1'b0;
        endcase
        w_done_next = (w_state_next == S_DONE);
    end

    // Row counter, S1/S2 pipeline and registered done flag; disabling flushes the valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_cnt  <= {CNT_W{1'b0}};
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_data  <= {ROW_W{1'b0}};
            r_s2_data  <= {ROW_W{1'b0}};
            r_done     <= 1'b0;
        end else if (!io_act.enable_activation) begin
            r_row_cnt  <= {CNT_W{1'b0}};
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row_cnt <= w_cnt_inc;
                r_s1_data <= w_act_row;
            end
            if (r_s1_valid) begin
                r_s2_data <= r_s1_data;
            end
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_done     <= w_done_next;
        end
    end

    // Output select: pipeline result when enabled, raw input when bypassed.
    always_comb begin
        if (io_act.enable_activation) begin
            io_act.out_data           = r_s2_data;
            io_act.out_data_available = r_s2_valid;
            io_act.done_activation    = r_done;
        end else begin
            io_act.out_data           = io_act.inp_data;
            io_act.out_data_available = io_act.in_data_available;
            io_act.done_activation    = 1'b0;
        end
    end
endmodule

// File: tb/tb_activation_unit.sv
// Randomized bench for activation_unit against a cycle-indexed behavioural model.
// Build with ACTIVATION_TANH_EN defined to exercise the tanh-PWL path.
module tb_activation_unit;
    localparam int DW = 8;
    localparam int DS = 16;
    localparam int MW = 16;
    localparam int RW = DW * DS;
`ifdef ACTIVATION_TANH_EN
    localparam bit TANH = 1'b1;
`else
    localparam bit TANH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    activation_if #(.DWIDTH(DW), .DESIGN_SIZE(DS), .MASK_WIDTH(MW)) act_if ();

    activation_unit #(.DWIDTH(DW), .DESIGN_SIZE(DS), .MASK_WIDTH(MW)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_act (act_if)
    );

    typedef struct {
        int          due;
        logic [RW-1:0] data;
    } pend_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    pend_t         pend[$];
    int            nacc = 0;
    int            done_at = -1;
    logic [RW-1:0] last_out = '0;

    function automatic logic [RW-1:0] rnd_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Specification arithmetic on signed integers, lane by lane.
    function automatic logic [RW-1:0] model_row(input logic [RW-1:0] x, input logic [MW-1:0] mask, input logic typ);
        logic [RW-1:0] r;
        int v, a, m;
        r = '0;
        for (int i = 0; i < DS; i++) begin
            v = $signed(x[i*DW +: DW]);
            if (!mask[i]) begin
                m = 0;
            end else if (TANH && typ) begin
                a = (v < 0) ? -v : v;
                m = (a < 32) ? a : ((a < 96) ? 32 + (a - 32) / 4 : 48);
                if (v < 0) m = -m;
            end else begin
                m = (v < 0) ? 0 : v;
            end
            r[i*DW +: DW] = m[7:0];
        end
        return r;
    endfunction

    // Drive one cycle and return what the outputs must show during it.
    task automatic run_cycle(input logic en, input logic typ, input logic v, input logic [RW-1:0] d,
                             input logic [MW-1:0] mask, output logic ev, output logic [RW-1:0] ed,
                             output logic edone);
        pend_t p;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        act_if.enable_activation = en;
        act_if.activation_type   = typ;
        act_if.in_data_available = v;
        act_if.inp_data          = d;
        act_if.validity_mask     = mask;
        if (!en) begin
            ev = v;
            ed = d;
            edone = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) last_out = pend[0].data;
            pend.delete();
            nacc = 0;
            done_at = -1;
        end else begin
            ev = 1'b0;
            edone = (done_at >= 0 && cyc >= done_at);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev = 1'b1;
                last_out = pend[0].data;
                void'(pend.pop_front());
            end
            ed = last_out;
            if (v && nacc < DS) begin
                p.due = cyc + 2;
                p.data = model_row(d, mask, typ);
                pend.push_back(p);
                nacc++;
                if (nacc == DS) done_at = cyc + 4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        act_if.enable_activation = 1'b1;
        act_if.activation_type   = 1'b0;
        act_if.in_data_available = 1'b0;
        act_if.inp_data          = '0;
        act_if.validity_mask     = '1;
        pend.delete();
        nacc = 0;
        done_at = -1;
        last_out = '0;
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic ev, edone;
        logic [RW-1:0] ed;
        do_reset();
        n_cmp++;
        if (act_if.out_data !== 128'h0) begin
            n_bad++; $display("FAIL reset_data got=%h exp=0", act_if.out_data);
        end
        n_cmp++;
        if (act_if.out_data_available !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got=%b exp=0", act_if.out_data_available);
        end
        n_cmp++;
        if (act_if.done_activation !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got=%b exp=0", act_if.done_activation);
        end
        run_cycle(1'b1, 1'b0, 1'b0, '0, '1, ev, ed, edone);
        n_cmp++;
        if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
            n_bad++; $display("FAIL reset_idle got=%h exp=%h", {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
        end
    endtask

    task automatic test_bypass();
        logic ev, edone;
        logic [RW-1:0] ed, row;
        for (int k = 0; k < 10; k++) begin
            row = rnd_row();
            if (k == 0) for (int i = 0; i < DS; i++) row[i*DW +: DW] = 8'(i - 8);
            run_cycle(1'b0, 1'($urandom), (k == 0) ? 1'b1 : 1'($urandom), row, 16'($urandom), ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL bypass cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
        end
    endtask

    task automatic test_relu_frame();
        logic ev, edone;
        logic [RW-1:0] ed, row;
        int first_acc, first_out, last_out_cyc, first_done, nout;
        first_acc = -1; first_out = -1; last_out_cyc = -100; first_done = -1; nout = 0;
        for (int k = 0; k < 22; k++) begin
            row = rnd_row();
            row[39:0] = 40'h7f_01_00_ff_80;
            if (k == 0) first_acc = cyc + 1;
            run_cycle(1'b1, 1'b0, (k < 16), row, 16'hFFFF, ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL relu cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            if (act_if.out_data_available === 1'b1) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    n_cmp++;
                    if (act_if.out_data[39:0] !== 40'h7f_01_00_00_00) begin
                        n_bad++; $display("FAIL relu_lanes got=%h exp=7f01000000", act_if.out_data[39:0]);
                    end
                end
                nout++;
                if (nout == 16) last_out_cyc = cyc;
            end
            if (act_if.done_activation === 1'b1 && first_done < 0) first_done = cyc;
        end
        n_cmp++;
        if (first_out - first_acc != 2) begin
            n_bad++; $display("FAIL relu_latency got=%0d exp=2", first_out - first_acc);
        end
        n_cmp++;
        if (first_done < 0 || first_done - last_out_cyc != 2) begin
            n_bad++; $display("FAIL done_delay got=%0d exp=2", first_done - last_out_cyc);
        end
        run_cycle(1'b0, 1'b0, 1'b0, '0, '1, ev, ed, edone);
        n_cmp++;
        if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
            n_bad++; $display("FAIL relu_exit got=%h exp=%h", {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
        end
    endtask

    task automatic test_mask();
        logic ev, edone, seen;
        logic [RW-1:0] ed, row, want;
        row = {16{8'd50}};
        want = {{8{8'h00}}, {8{8'h32}}};
        seen = 1'b0;
        for (int k = 0; k < 23; k++) begin
            run_cycle((k < 22), 1'b0, (k < 16), row, 16'h00FF, ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL mask cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            if (!seen && act_if.out_data_available === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (act_if.out_data !== want) begin
                    n_bad++; $display("FAIL mask_lanes got=%h exp=%h", act_if.out_data, want);
                end
            end
        end
    endtask

    task automatic test_gaps_drops();
        logic ev, edone;
        logic [RW-1:0] ed;
        logic sched[$];
        int pulses, idx17;
        for (int r = 0; r < 16; r++) begin
            for (int g = $urandom_range(3, 0); g > 0; g--) sched.push_back(1'b0);
            sched.push_back(1'b1);
        end
        for (int g = 0; g < 8; g++) sched.push_back(1'b0);
        idx17 = sched.size();
        sched.push_back(1'b1);
        for (int g = 0; g < 4; g++) sched.push_back(1'b0);
        pulses = 0;
        for (int k = 0; k < sched.size(); k++) begin
            run_cycle(1'b1, 1'($urandom), sched[k], rnd_row(), 16'($urandom), ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL gaps cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            if (act_if.out_data_available === 1'b1) pulses++;
            if (k == idx17) begin
                n_cmp++;
                if (act_if.done_activation !== 1'b1) begin
                    n_bad++; $display("FAIL done_held got=%b exp=1", act_if.done_activation);
                end
            end
        end
        n_cmp++;
        if (pulses != 16) begin
            n_bad++; $display("FAIL gap_pulses got=%0d exp=16", pulses);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            run_cycle((k != 0 && k != 5), 1'b0, (k == 1), rnd_row(), '1, ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL reidle cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            if (act_if.out_data_available === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++; $display("FAIL reidle_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_abort();
        logic ev, edone;
        logic [RW-1:0] ed;
        int dones, outs;
        for (int variant = 0; variant < 2; variant++) begin
            dones = 0;
            for (int k = 0; k < 7; k++) begin
                run_cycle(1'b1, 1'($urandom), 1'b1, rnd_row(), 16'($urandom), ev, ed, edone);
                n_cmp++;
                if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                    n_bad++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
                end
            end
            if (variant == 0) begin
                run_cycle(1'b0, 1'b0, 1'b0, rnd_row(), '1, ev, ed, edone);
            end else begin
                do_reset();
                ev = 1'b0; edone = 1'b0; ed = '0;
            end
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL abort_cut v=%0d got=%h exp=%h", variant, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            for (int k = 0; k < 6; k++) begin
                run_cycle(1'b1, 1'b0, 1'b0, rnd_row(), '1, ev, ed, edone);
                n_cmp++;
                if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                    n_bad++; $display("FAIL abort_idle cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
                end
                if (act_if.done_activation === 1'b1) dones++;
            end
            n_cmp++;
            if (dones != 0) begin
                n_bad++; $display("FAIL abort_nodone v=%0d got=%0d exp=0", variant, dones);
            end
            outs = 0; dones = 0;
            for (int k = 0; k < 22; k++) begin
                run_cycle(1'b1, 1'($urandom), (k < 16), rnd_row(), 16'($urandom), ev, ed, edone);
                n_cmp++;
                if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                    n_bad++; $display("FAIL abort_next cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
                end
                if (act_if.out_data_available === 1'b1) outs++;
                if (act_if.done_activation === 1'b1) dones++;
            end
            n_cmp++;
            if (outs != 16 || dones == 0) begin
                n_bad++; $display("FAIL abort_frame v=%0d got outs=%0d dones=%0d exp outs=16 dones>0", variant, outs, dones);
            end
            run_cycle(1'b0, 1'b0, 1'b0, '0, '1, ev, ed, edone);
        end
    endtask

    task automatic test_tanh();
        logic ev, edone, seen;
        logic [RW-1:0] ed, row;
        logic [55:0] want;
`ifdef ACTIVATION_TANH_EN
        want = 56'h30_d0_30_de_22_f6_0a;
`else
        want = 56'h7f_00_60_00_28_00_0a;
`endif
        seen = 1'b0;
        for (int k = 0; k < 23; k++) begin
            row = rnd_row();
            if (k == 0) row[55:0] = 56'h7f_80_60_d8_28_f6_0a;
            run_cycle((k < 22), (k == 0) ? 1'b1 : 1'($urandom), (k < 16), row, (k == 0) ? 16'hFFFF : 16'($urandom), ev, ed, edone);
            n_cmp++;
            if ({act_if.out_data_available, act_if.done_activation, act_if.out_data} !== {ev, edone, ed}) begin
                n_bad++; $display("FAIL tanh cyc=%0d got=%h exp=%h", cyc, {act_if.out_data_available, act_if.done_activation, act_if.out_data}, {ev, edone, ed});
            end
            if (!seen && act_if.out_data_available === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (act_if.out_data[55:0] !== want) begin
                    n_bad++; $display("FAIL tanh_lanes got=%h exp=%h", act_if.out_data[55:0], want);
                end
            end
        end
    endtask

    initial begin
        act_if.enable_activation = 1'b0;
        act_if.activation_type   = 1'b0;
        act_if.in_data_available = 1'b0;
        act_if.inp_data          = '0;
        act_if.validity_mask     = '1;
        test_reset();
        test_bypass();
        test_relu_frame();
        test_mask();
        test_gaps_drops();
        test_abort();
        test_tanh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
